vga_sync_decoder: RTL

- Receive side of our VGA timing interface. Consumes an active-low Hsync/Vsync pair on a pixel-clock-enable grid and recovers the row and column of each pixel, plus an active-pixel flag.
- Measures line length and frame height, and declares lock only after the timing has been stable for several frames.
- Used to check the VGA timing generator in-system and as the front end of the frame-capture path.

---
 rtl/vga_sync_decoder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive side of the VGA timing interface. Recovers the pixel row and
//   column from an active-low Hsync/Vsync pair sampled on a pixel clock
//   enable, measures line length and frame height, and declares lock once
//   the timing has repeated for LOCK_FRAMES consecutive frames.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   pix_ce       pixel clock enable; sampling and counting only when 1
//   Hsync        horizontal sync, active low
//   Vsync        vertical sync, active low
//   row          recovered active row, 0 outside the active window
//   col          recovered active column, 0 outside the active window
//   active       pixel inside the active window while locked
//   locked       timing lock achieved
//   err          one-clk pulse when lock is lost
//   line_len     most recently measured line length (ce cycles)
//   frame_lines  most recently measured frame height (lines)
module vga_sync_decoder #(
   parameter int H_ACT_START = 144,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACT_START = 34,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_ce,
   input  logic        Hsync,
   input  logic        Vsync,
   output logic [8:0]  row,
   output logic [9:0]  col,
   output logic        active,
   output logic        locked,
   output logic        err,
   output logic [10:0] line_len,
   output logic [9:0]  frame_lines
);

   localparam logic [10:0] H_MAX = 11'h7FF;
   localparam logic [9:0]  V_MAX = 10'h3FF;
   localparam logic [10:0] H_LO  = 11'(H_ACT_START);
   localparam logic [10:0] H_HI  = 11'(H_ACT_START + H_ACTIVE);
   localparam logic [9:0]  V_LO  = 10'(V_ACT_START);
   localparam logic [9:0]  V_HI  = 10'(V_ACT_START + V_ACTIVE);
   localparam int          MW    = $clog2(LOCK_FRAMES + 1);
   localparam logic [MW-1:0] MATCH_TGT = MW'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   state_t        state, state_nxt;
   logic          hs_q, vs_q, vs_pend;
   logic [10:0]   h_cnt, h_inc;
   logic [9:0]    v_cnt, v_inc;
   logic [10:0]   ref_len, ref_len_nxt;
   logic [9:0]    ref_frame, ref_frame_nxt;
   logic          ref_vld, ref_vld_nxt;
   logic          frame_bad, frame_bad_nxt;
   logic [MW-1:0] match_cnt, match_nxt;
   logic          hs_fall, vs_fall, frame_bnd;
   logic          h_sat, v_sat, sat, len_bad, lose;
   logic          hwin, vwin;

   // Edge detects are qualified by pix_ce so every event below is a ce event.
   assign hs_fall   = pix_ce & hs_q & ~Hsync;
   assign vs_fall   = pix_ce & vs_q & ~Vsync;
   // A Vsync fall coincident with an Hsync fall makes that Hsync fall the boundary.
   assign frame_bnd = hs_fall & (vs_pend | vs_fall);

   // Saturating increments double as the new measurements (count + 1).
   assign h_inc = (h_cnt == H_MAX) ? H_MAX : h_cnt + 11'd1;
   assign v_inc = (v_cnt == V_MAX) ? V_MAX : v_cnt + 10'd1;

   assign h_sat   = pix_ce & ~hs_fall & (h_inc == H_MAX);
   assign v_sat   = hs_fall & ~frame_bnd & (v_inc == V_MAX);
   assign sat     = h_sat | v_sat;
   assign len_bad = hs_fall & (h_inc != ref_len);

   assign hwin = (h_cnt >= H_LO) && (h_cnt < H_HI);
   assign vwin = (v_cnt >= V_LO) && (v_cnt < V_HI);

   always_comb begin
      state_nxt     = state;
      match_nxt     = match_cnt;
      ref_len_nxt   = ref_len;
      ref_frame_nxt = ref_frame;
      ref_vld_nxt   = ref_vld;
      frame_bad_nxt = frame_bad;
      lose          = 1'b0;
      unique case (state)
         SEARCH: begin
            if (frame_bnd) begin
               state_nxt     = ACQUIRE;
               match_nxt     = '0;
               ref_len_nxt   = h_inc;
               ref_vld_nxt   = 1'b0;
               frame_bad_nxt = 1'b0;
            end
         end
         ACQUIRE: begin
            if (sat) begin
               state_nxt = SEARCH;
            end else if (frame_bnd) begin
               // The line closed by this boundary still belongs to the frame being judged.
               if (ref_vld && !frame_bad && !len_bad && (v_inc == ref_frame))
                  match_nxt = match_cnt + MW'(1);
               else
                  match_nxt = '0;
               ref_frame_nxt = v_inc;
               ref_vld_nxt   = 1'b1;
               ref_len_nxt   = h_inc;
               frame_bad_nxt = 1'b0;
               if (match_nxt == MATCH_TGT)
                  state_nxt = LOCKED;
            end else if (len_bad) begin
               frame_bad_nxt = 1'b1;
            end
         end
         LOCKED: begin
            if (sat || len_bad || (frame_bnd && (v_inc != ref_frame))) begin
               lose      = 1'b1;
               state_nxt = SEARCH;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SEARCH;
         locked    <= 1'b0;
         err       <= 1'b0;
         match_cnt <= '0;
         ref_len   <= '0;
         ref_frame <= '0;
         ref_vld   <= 1'b0;
         frame_bad <= 1'b0;
      end else begin
         // lose is only ever set on a ce, so err always clears on the next clk.
         err <= lose;
         if (pix_ce) begin
            state     <= state_nxt;
            locked    <= (state_nxt == LOCKED);
            match_cnt <= match_nxt;
            ref_len   <= ref_len_nxt;
            ref_frame <= ref_frame_nxt;
            ref_vld   <= ref_vld_nxt;
            frame_bad <= frame_bad_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         vs_pend     <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         line_len    <= '0;
         frame_lines <= '0;
      end else if (pix_ce) begin
         hs_q <= Hsync;
         vs_q <= Vsync;
         if (hs_fall) begin
            h_cnt    <= '0;
            line_len <= h_inc;
         end else begin
            h_cnt <= h_inc;
         end
         if (frame_bnd) begin
            v_cnt       <= '0;
            frame_lines <= v_inc;
            vs_pend     <= 1'b0;
         end else begin
            if (hs_fall)
               v_cnt <= v_inc;
            vs_pend <= vs_pend | vs_fall;
         end
      end
   end

   // Window outputs follow the counters by one clk; the subtraction is only
   // taken inside the window so it cannot wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         col    <= '0;
         row    <= '0;
         active <= 1'b0;
      end else begin
         col    <= hwin ? 10'(h_cnt - H_LO) : 10'd0;
         row    <= vwin ? 9'(v_cnt - V_LO) : 9'd0;
         active <= hwin & vwin & locked;
      end
   end

endmodule
